// File: rtl/prbs13_checker.sv
// prbs13_checker -- receive-side PRBS-13 (x^13+x^12+x^2+x+1) bit-error checker.
//
// Self-synchronises a local predictor to the incoming serial stream. While
// searching, the history is loaded from the line. Once LOCK_CNT consecutive
// predictions are correct, the predictor free-runs. Every valid bit is then
// compared, and saturating bit/error counters are accumulated.
//
// Optional feature macro: PRBS13_CHK_AUTO_UNLOCK_EN
//   defined   -> windowed loss-of-lock (UNLOCK_ERRS errors in WIN_LEN bits)
//   undefined -> LOCKED is left only via resync or reset
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous, active-low
//   rx_valid   rx_bit is valid this cycle
//   rx_bit     received serial bit
//   clear      synchronous zeroing of bit_count / err_count
//   resync     synchronous force back to SEARCH
//   locked     checker is in LOCKED
//   err_pulse  one-cycle strobe per detected bit error
//   bit_count  bits compared while locked (saturating)
//   err_count  mismatching bits while locked (saturating)
module prbs13_checker #(
    parameter int LOCK_CNT    = 32,
    parameter int WIN_LEN     = 64,
    parameter int UNLOCK_ERRS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic        rx_bit,
    input  logic        clear,
    input  logic        resync,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] bit_count,
    output logic [31:0] err_count
);

    // Elaboration-time range checks on the configuration.
    if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock_cnt
        $error("prbs13_checker: LOCK_CNT out of range");
    end
    if (WIN_LEN < 16 || WIN_LEN > 1024 || (WIN_LEN & (WIN_LEN - 1)) != 0) begin : g_bad_win_len
        $error("prbs13_checker: WIN_LEN must be a power of two in 16..1024");
    end
    if (UNLOCK_ERRS < 1 || UNLOCK_ERRS > WIN_LEN) begin : g_bad_unlock_errs
        $error("prbs13_checker: UNLOCK_ERRS out of range");
    end

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [12:0] h, h_nxt;
    logic [3:0]  fill, fill_nxt;
    logic [7:0]  match, match_nxt;
    logic        err_nxt;
    logic [31:0] bc_nxt, ec_nxt;
    logic        pred, miss;

`ifdef PRBS13_CHK_AUTO_UNLOCK_EN
    localparam int WB_W = $clog2(WIN_LEN);
    localparam int WE_W = $clog2(UNLOCK_ERRS + 1);
    logic [WB_W-1:0] win_bits, win_bits_nxt;
    logic [WE_W-1:0] win_errs, win_errs_nxt, win_errs_inc;
`endif

    assign pred = h[0] ^ h[1] ^ h[11] ^ h[12];
    assign miss = rx_bit ^ pred;

    always_comb begin
        state_nxt = state;
        h_nxt     = h;
        fill_nxt  = fill;
        match_nxt = match;
        err_nxt   = 1'b0;
        bc_nxt    = bit_count;
        ec_nxt    = err_count;
`ifdef PRBS13_CHK_AUTO_UNLOCK_EN
        win_bits_nxt = win_bits;
        win_errs_nxt = win_errs;
        win_errs_inc = win_errs + 1'b1;
`endif
        if (resync) begin
            // The bit sampled alongside resync is dropped.
            state_nxt = SEARCH;
            fill_nxt  = '0;
            match_nxt = '0;
`ifdef PRBS13_CHK_AUTO_UNLOCK_EN
            win_bits_nxt = '0;
            win_errs_nxt = '0;
`endif
        end else begin
            if (rx_valid) begin
                if (state == SEARCH) begin
                    h_nxt = {h[11:0], rx_bit};
                    if (fill != 4'd13) fill_nxt = fill + 4'd1;
                    if (fill == 4'd13) begin
                        // All-zero history never counts: stuck-at-0 must not lock.
                        if (!miss && h != '0) begin
                            match_nxt = match + 8'd1;
                            if (match_nxt == 8'(LOCK_CNT)) state_nxt = LOCKED;
                        end else begin
                            match_nxt = '0;
                        end
                    end
                end else begin
                    // Free-running predictor: one line error yields one count.
                    h_nxt   = {h[11:0], pred};
                    err_nxt = miss;
                    if (bit_count != '1) bc_nxt = bit_count + 32'd1;
                    if (miss && err_count != '1) ec_nxt = err_count + 32'd1;
`ifdef PRBS13_CHK_AUTO_UNLOCK_EN
                    win_bits_nxt = win_bits + 1'b1;  // wraps at WIN_LEN
                    if (miss && win_errs_inc == WE_W'(UNLOCK_ERRS)) begin
                        state_nxt    = SEARCH;
                        fill_nxt     = '0;
                        match_nxt    = '0;
                        win_bits_nxt = '0;
                        win_errs_nxt = '0;
                    end else if (win_bits == WB_W'(WIN_LEN - 1)) begin
                        win_errs_nxt = '0;
                    end else if (miss) begin
                        win_errs_nxt = win_errs_inc;
                    end
`endif
                end
            end
            if (clear) begin
                bc_nxt = '0;
                ec_nxt = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            h         <= '0;
            fill      <= '0;
            match     <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
`ifdef PRBS13_CHK_AUTO_UNLOCK_EN
            win_bits  <= '0;
            win_errs  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            h         <= h_nxt;
            fill      <= fill_nxt;
            match     <= match_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= err_nxt;
            bit_count <= bc_nxt;
            err_count <= ec_nxt;
`ifdef PRBS13_CHK_AUTO_UNLOCK_EN
            win_bits  <= win_bits_nxt;
            win_errs  <= win_errs_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_prbs13_checker.sv
// tb_prbs13_checker -- directed self-checking bench for prbs13_checker.
// A reference PRBS-13 generator (seed 0x1FFF) supplies the stream. Expected
// values are hand-derived: lock after valid bit 13 + 32 = 45, and so on.
module tb_prbs13_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_bit = 1'b0;
    logic        clear = 1'b0;
    logic        resync = 1'b0;
    logic        locked, err_pulse;
    logic [31:0] bit_count, err_count;

    int          total = 0;
    int          passed = 0;
    int          fails = 0;
    logic        ep_seen = 1'b0;
    logic [12:0] g = 13'h1FFF;
    logic [31:0] bc0;

    prbs13_checker #(.LOCK_CNT(32), .WIN_LEN(64), .UNLOCK_ERRS(8)) dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_bit(rx_bit),
        .clear(clear), .resync(resync), .locked(locked), .err_pulse(err_pulse),
        .bit_count(bit_count), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic b, input logic cl, input logic rs);
        rx_valid = v;
        rx_bit   = b;
        clear    = cl;
        resync   = rs;
        @(posedge clock);
        #1;
        if (err_pulse) ep_seen = 1'b1;
        rx_valid = 1'b0;
        clear    = 1'b0;
        resync   = 1'b0;
    endtask

    // Next generator bit, optionally inverted on the line.
    task automatic gbit(input logic inv, input logic cl);
        logic nb;
        nb = g[0] ^ g[1] ^ g[11] ^ g[12];
        g  = {g[11:0], nb};
        step(1'b1, nb ^ inv, cl, 1'b0);
    endtask

    task automatic relock(input string tag);
        for (int i = 1; i <= 45; i++) begin
            gbit(1'b0, 1'b0);
            if (i == 44) chk({tag, "_unlocked_at_44"}, {31'd0, locked}, 32'd0);
            if (i == 45) chk({tag, "_locked_at_45"}, {31'd0, locked}, 32'd1);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst_bit_count", bit_count, 32'd0);
        chk("rst_err_count", err_count, 32'd0);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        // 200 clean bits
        ep_seen = 1'b0;
        relock("clean");
        for (int i = 0; i < 155; i++) gbit(1'b0, 1'b0);
        chk("clean_bit_count", bit_count, 32'd155);
        chk("clean_err_count", err_count, 32'd0);
        chk("clean_no_err_pulse", {31'd0, ep_seen}, 32'd0);

        // Single inverted bit
        gbit(1'b1, 1'b0);
        chk("single_err_pulse", {31'd0, err_pulse}, 32'd1);
        chk("single_err_count", err_count, 32'd1);
        chk("single_locked", {31'd0, locked}, 32'd1);
        gbit(1'b0, 1'b0);
        chk("single_pulse_drop", {31'd0, err_pulse}, 32'd0);
        for (int i = 0; i < 99; i++) gbit(1'b0, 1'b0);
        chk("single_err_hold", err_count, 32'd1);
        chk("single_bit_count", bit_count, 32'd256);

        // Clear, then 8 errors within one window
        gbit(1'b0, 1'b1);
        chk("burst_clear_bc", bit_count, 32'd0);
        chk("burst_clear_ec", err_count, 32'd0);
        for (int k = 0; k < 32; k++) begin
            gbit(k % 4 == 3, 1'b0);
            if (k == 30) chk("burst_locked_before_8th", {31'd0, locked}, 32'd1);
        end
`ifdef PRBS13_CHK_AUTO_UNLOCK_EN
        chk("burst_unlock", {31'd0, locked}, 32'd0);
        chk("burst_err_count", err_count, 32'd8);
        relock("burst_relock");
`else
        chk("burst_stay_locked", {31'd0, locked}, 32'd1);
        chk("burst_err_count", err_count, 32'd8);
`endif

        // rx_valid toggling, then clear mid-stream
        bc0 = bit_count;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) gbit(1'b0, 1'b0);
            else begin
                step(1'b0, 1'b1, 1'b0, 1'b0);
                chk("toggle_idle_pulse", {31'd0, err_pulse}, 32'd0);
            end
            chk("toggle_bit_count", bit_count, bc0 + 32'(i / 2 + 1));
        end
        gbit(1'b0, 1'b1);
        chk("clear_bc", bit_count, 32'd0);
        chk("clear_ec", err_count, 32'd0);
        for (int i = 0; i < 20; i++) gbit(1'b0, 1'b0);
        chk("resume_bc", bit_count, 32'd20);
        chk("resume_ec", err_count, 32'd0);

        // resync with a valid bit: bit dropped, unlock next edge
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("resync_unlock", {31'd0, locked}, 32'd0);
        chk("resync_bc_hold", bit_count, 32'd20);
        relock("resync_relock");

        // Asynchronous reset between edges
        gbit(1'b1, 1'b0);
        chk("pre_areset_pulse", {31'd0, err_pulse}, 32'd1);
        #3 reset = 1'b0;
        #1;
        chk("areset_locked", {31'd0, locked}, 32'd0);
        chk("areset_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("areset_bc", bit_count, 32'd0);
        chk("areset_ec", err_count, 32'd0);
        #2 reset = 1'b1;
        relock("areset_relock");

        // Stuck-at-0 line never locks
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("zeros_locked", {31'd0, locked}, 32'd0);
        chk("zeros_bc", bit_count, 32'd0);
        chk("zeros_ec", err_count, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
